// File: rtl/pc_stack_seq.sv
// pc_stack_seq: next-PC sequencer with jump/branch/skip and a LIFO return stack
module pc_stack_seq #(
  parameter int PC_W = 17,
  parameter int STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  localparam int LW = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [2:0]      op,
  input  logic [PC_W-1:0] target,
  input  logic            cond,
  output logic [PC_W-1:0] counter,
  output logic [LW-1:0]   level,
  output logic            stack_full,
  output logic            stack_empty,
  output logic            ovf,
  output logic            unf,
  output logic            err
);
  localparam int AW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  localparam logic [2:0] OP_HOLD = 3'd0, OP_JUMP = 3'd2, OP_BR_IF = 3'd3,
                         OP_SKIP_IF = 3'd4, OP_CALL = 3'd5, OP_RET = 3'd6;
  logic [PC_W-1:0] stack [2**AW];
  logic [PC_W-1:0] inc1, inc2, pc_n;
  logic [LW-1:0]   lvl_m1, level_n;
  logic            push, pop, ovf_n, unf_n;
  assign stack_full  = level == LW'(STACK_DEPTH);
  assign stack_empty = level == '0;
  assign lvl_m1      = level - LW'(1);
  // next-state decode; faulted CALL/RET and reserved op fall through to increment
  always_comb begin
    inc1    = counter + PC_W'(1);
    inc2    = counter + PC_W'(2);
    push    = en && op == OP_CALL && !stack_full;
    pop     = en && op == OP_RET && !stack_empty;
    ovf_n   = en && op == OP_CALL && stack_full;
    unf_n   = en && op == OP_RET && stack_empty;
    level_n = push ? level + LW'(1) : pop ? lvl_m1 : level;
    pc_n    = !en                ? counter :
              op == OP_HOLD      ? counter :
              op == OP_JUMP      ? target :
              op == OP_BR_IF     ? (cond ? target : inc1) :
              op == OP_SKIP_IF   ? (cond ? inc2 : inc1) :
              push               ? target :
              pop                ? stack[lvl_m1[AW-1:0]] :
              inc1;
  end
  // PC, level and fault flags; reset overrides everything including en
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= RESET_VEC;
      level   <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      counter <= pc_n;
      level   <= level_n;
      ovf     <= ovf_n;
      unf     <= unf_n;
      err     <= err | ovf_n | unf_n;
    end
  end
  // return-address storage; contents are not cleared, level alone marks validity
  always_ff @(posedge clk) begin
    if (push && !reset) stack[level[AW-1:0]] <= inc1;
  end
endmodule

// File: doc/pc_stack_seq.md
Name: pc_stack_seq

Overview:
- Parametrised successor to the flat program counter: the next-PC sequencer for the accumulator CPU (decode / alu / w_reg datapath).
- Beyond plain increment, it supports absolute jump, conditional branch, conditional skip, and call/return through an internal LIFO return stack of configurable depth.
- Driven each cycle by an op code from the decoder and a condition bit from the W/carry logic.

Parameters:
- PC_W, 17, program counter width in bits.
- STACK_DEPTH, 4, number of return-address entries (>=1).
- RESET_VEC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 = freeze all state.
- op  in  3  sequencer operation (encoding below).
- target  in  PC_W  absolute destination for JUMP/BR_IF/CALL.
- cond  in  1  condition for BR_IF/SKIP_IF (e.g. carry or W==0).
- counter  out  PC_W  current PC, registered.
- level  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  out  1  level == STACK_DEPTH.
- stack_empty  out  1  level == 0.
- ovf  out  1  one-cycle pulse: CALL attempted while full.
- unf  out  1  one-cycle pulse: RET attempted while empty.
- err  out  1  sticky OR of ovf/unf; cleared only by reset.

Behaviour:
- All state updates on the rising clk edge. Outputs are registered; a new counter is visible the cycle after the op is sampled (1-cycle latency).
- Reset (sync, highest priority, overrides en):
  - counter = RESET_VEC, level = 0, ovf = unf = err = 0.
  - stack_empty = 1, stack_full = 0.
  - Stack contents need not be cleared.
- en = 0: counter, level, stack and err hold; ovf and unf = 0; op ignored.
- Ops (en = 1); all PC arithmetic is modulo 2^PC_W, so max+1 -> 0 and max+2 -> 1:
  - 000 HOLD: counter unchanged.
  - 001 INC: counter + 1.
  - 010 JUMP: target.
  - 011 BR_IF: cond ? target : counter + 1.
  - 100 SKIP_IF: cond ? counter + 2 : counter + 1.
  - 101 CALL: push (counter + 1) mod 2^PC_W; counter = target; level + 1.
  - 110 RET: counter = top of stack; level - 1.
  - 111 reserved: behaves as INC.
- CALL when stack_full:
  - no push; stack and level unchanged; counter = counter + 1.
  - ovf = 1 for that cycle; err set.
- RET when stack_empty:
  - counter = counter + 1; level unchanged.
  - unf = 1 for that cycle; err set.
- ovf and unf are 0 on every cycle without the corresponding fault. Both are never 1 together.
- The stack is strictly LIFO, and a RET returns the most recent unpopped push.
- A CALL immediately after a RET reuses the freed slot.
- stack_full and stack_empty are derived from registered level and are valid in the same cycle as level.
- Reset asserted mid-sequence (e.g. with level = 3) discards all return addresses. The next RET after reset flags unf.
- No combinational path from any input to any output.

Test Plan:
- Reset and increment:
  - Stimulus: reset = 1 for 1 cycle, then en = 1, op = INC for 5 cycles.
  - Response: counter 0, 1, 2, 3, 4, 5; level = 0; stack_empty = 1; err = 0.
- Jump, branch and skip (start at counter = 10):
  - JUMP target = 100 -> 100.
  - BR_IF cond = 0, target = 7 -> 101.
  - BR_IF cond = 1, target = 7 -> 7.
  - SKIP_IF cond = 1 -> 9.
  - SKIP_IF cond = 0 -> 10.
- Nested call/return (from counter = 20):
  - CALL 50 -> counter 50, level 1.
  - CALL 80 -> counter 80, level 2.
  - RET -> 51, level 1.
  - RET -> 21, level 0, stack_empty = 1.
- Overflow and underflow (STACK_DEPTH = 4):
  - Four CALLs -> stack_full = 1.
  - Fifth CALL from counter = 300 -> counter 301, ovf pulses 1 cycle, level stays 4, err = 1.
  - Four RETs return the pushed addresses in reverse order.
  - Fifth RET -> unf pulses, counter + 1, level 0, err remains 1.
- Wrap-around and enable:
  - JUMP 131071, then INC -> 0.
  - JUMP 131071, then CALL 5 -> pushes 0; RET -> 0.
  - SKIP_IF cond = 1 at 131070 -> 0.
  - en = 0 with op = JUMP for 3 cycles -> counter, level and err unchanged; ovf = unf = 0.
- Reset mid-operation:
  - At level = 3, err = 1, counter = 400, assert reset while en = 1 and op = CALL.
  - Next cycle: counter = 0, level = 0, err = 0.
  - Then RET -> unf = 1, counter = 1.
